gate_exerciser: RTL and testbench

GATE_EXERCISER -- requirements
Module: gate_exerciser

---
 rtl/gate_exerciser.sv | 181 ++++++++++++++++++
 tb/tb_gate_exerciser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_exerciser.sv
// Truth-table exerciser for a 2-input gate: drives the four (a,b) vectors in turn,
// lets each settle, samples the gate response and reports per-vector mismatches.
//
// state  | meaning
// IDLE   | waiting for start; stimulus held at 0, results held from last sweep
// SETTLE | current vector driven, waiting SETTLE_CYCLES cycles
// SAMPLE | compare y_in against the expected function for the current vector
// DONE   | one-cycle done pulse, results final, stimulus back to 0
module gate_exerciser #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] func_sel,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       bad_func,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] func_q, func_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       bad_q, bad_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic       mismatch;
  logic [2:0] err_next;
  logic [1:0] idx_inc;

  function automatic logic expected_y(input logic [2:0] f, input logic a, input logic b);
    logic y;
    case (f)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~(a & b);
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  assign mismatch = (y_in != expected_y(func_q, a_q, b_q));
  assign err_next = (mismatch && (err_q != 3'd4)) ? err_q + 3'd1 : err_q;
  assign idx_inc  = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    bad_d   = bad_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          func_d = func_sel;
          pass_d = 1'b0;
          err_d  = 3'd0;
          fail_d = 4'd0;
          idx_d  = 2'd0;
          cnt_d  = 4'd0;
          a_d    = 1'b0;
          b_d    = 1'b0;
          // Codes 6 and 7 have no gate function: skip straight to the result.
          if (func_sel >= 3'd6) begin
            bad_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            bad_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SAMPLE: begin
        err_d         = err_next;
        fail_d[idx_q] = fail_q[idx_q] | mismatch;
        if (idx_q == 2'd3) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == 3'd0) && !bad_q;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_inc;
          a_d     = idx_inc[1];
          b_d     = idx_inc[0];
          state_d = S_SETTLE;
        end
      end

      default: begin
        idx_d   = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      func_q  <= 3'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign bad_func  = bad_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two instances (SETTLE_CYCLES 2 and 1) each driving a modelled
// gate; sweeps are checked against a truth-table reference model.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [2:0] fs0, fs1;
  logic       y0, y1;
  logic       a0, b0, busy0, done0, pass0, bad0;
  logic       a1, b1, busy1, done1, pass1, bad1;
  logic [2:0] err0, err1;
  logic [3:0] fail0, fail1;

  int g0 = 0, g1 = 0;
  int u = 0;
  int n_checks = 0, n_pass = 0;

  gate_exerciser #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .func_sel(fs0),
    .a_out(a0), .b_out(b0), .y_in(y0), .busy(busy0), .done(done0),
    .pass(pass0), .bad_func(bad0), .err_count(err0), .fail_vec(fail0)
  );

  gate_exerciser #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .func_sel(fs1),
    .a_out(a1), .b_out(b1), .y_in(y1), .busy(busy1), .done(done1),
    .pass(pass1), .bad_func(bad1), .err_count(err1), .fail_vec(fail1)
  );

  // Truth table indexed by {a,b}
  function automatic logic [3:0] tt(input int f);
    case (f)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0111;
      3: return 4'b0001;
      4: return 4'b0110;
      5: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Gate under test: kinds 0..5 as func_sel codes, 6 = tied 1, 7 = tied 0
  function automatic logic gate_y(input int g, input logic a, input logic b);
    logic [3:0] t;
    if (g == 6) return 1'b1;
    if (g == 7) return 1'b0;
    t = tt(g);
    return t[{a, b}];
  endfunction

  always_comb y0 = gate_y(g0, a0, b0);
  always_comb y1 = gate_y(g1, a1, b1);

  logic       ca, cb, cbusy, cdone, cpass, cbad;
  logic [2:0] cerr;
  logic [3:0] cfail;
  always_comb begin
    ca    = (u == 1) ? a1    : a0;
    cb    = (u == 1) ? b1    : b0;
    cbusy = (u == 1) ? busy1 : busy0;
    cdone = (u == 1) ? done1 : done0;
    cpass = (u == 1) ? pass1 : pass0;
    cbad  = (u == 1) ? bad1  : bad0;
    cerr  = (u == 1) ? err1  : err0;
    cfail = (u == 1) ? fail1 : fail0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s (unit %0d): got %0d expected %0d", tag, u, got, exp);
  endtask

  task automatic drive_start(input logic v);
    if (u == 1) start1 = v; else start0 = v;
  endtask

  task automatic drive_fs(input logic [2:0] f);
    if (u == 1) fs1 = f; else fs0 = f;
  endtask

  task automatic set_gate(input int g);
    if (u == 1) g1 = g; else g0 = g;
  endtask

  task automatic model(input int g, input int f,
                       output int e_fail, output int e_err, output int e_pass, output int e_bad);
    logic [3:0] t;
    logic [3:0] fv;
    fv = 4'd0;
    if (f >= 6) begin
      e_bad = 1; e_fail = 0; e_err = 0; e_pass = 0;
    end else begin
      t = tt(f);
      for (int i = 0; i < 4; i++)
        fv[i] = (gate_y(g, i[1], i[0]) != t[i]);
      e_bad  = 0;
      e_fail = int'(fv);
      e_err  = $countones(fv);
      e_pass = (e_err == 0) ? 1 : 0;
    end
  endtask

  task automatic run_sweep(input int g, input int f, input bit hold, input bit toggle);
    int s, lat, busy_cnt, vec_bad, k, v;
    int e_fail, e_err, e_pass, e_bad;
    bit seen;
    logic ea, eb;
    s = (u == 1) ? 1 : 2;
    busy_cnt = 0; vec_bad = 0; seen = 0;
    model(g, f, e_fail, e_err, e_pass, e_bad);
    lat = (f >= 6) ? 0 : 4 * (s + 1);
    set_gate(g);
    @(negedge clk);
    drive_fs(3'(f));
    drive_start(1'b1);
    @(posedge clk); #1;
    if (!hold) drive_start(1'b0);
    for (k = 0; k <= 60; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (toggle) drive_fs(3'($urandom_range(0, 7)));
      if (cbusy) busy_cnt++;
      ea = 1'b0; eb = 1'b0;
      if (f < 6 && k < lat) begin
        v  = k / (s + 1);
        ea = v[1]; eb = v[0];
      end
      if (ca !== ea || cb !== eb) vec_bad++;
      if (cdone === 1'b1) begin seen = 1; break; end
    end
    drive_start(1'b0);
    chk("done_seen", int'(seen), 1);
    chk("latency", k, lat);
    chk("busy_cycles", busy_cnt, lat);
    chk("vector_seq", vec_bad, 0);
    chk("pass", int'(cpass), e_pass);
    chk("bad_func", int'(cbad), e_bad);
    chk("err_count", int'(cerr), e_err);
    chk("fail_vec", int'(cfail), e_fail);
    @(posedge clk); #1;
    chk("done_pulse_width", int'(cdone), 0);
    @(posedge clk); #1;
    chk("hold_results", int'({cpass, cbad, cerr, cfail}),
        (e_pass << 8) | (e_bad << 7) | (e_err << 4) | e_fail);
    chk("idle_outputs", int'({cbusy, cdone, ca, cb}), 0);
  endtask

  int done_cnt;

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    fs0 = 3'd0; fs1 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u0", int'({a0, b0, busy0, done0, pass0, bad0, err0, fail0}), 0);
    chk("reset_u1", int'({a1, b1, busy1, done1, pass1, bad1, err1, fail1}), 0);
    rst = 1'b0;

    u = 0;
    run_sweep(3, 3, 0, 0);   // NOR gate, expect NOR
    run_sweep(3, 0, 0, 0);   // NOR gate, expect AND
    run_sweep(6, 5, 0, 0);   // tied 1, expect XNOR
    run_sweep(3, 7, 0, 0);   // invalid function

    // Reset during SETTLE of vector 2
    set_gate(3);
    @(negedge clk);
    drive_fs(3'd0);
    drive_start(1'b1);
    @(posedge clk); #1;
    drive_start(1'b0);
    repeat (6) begin @(posedge clk); #1; end
    chk("vec2_before_rst", int'({ca, cb, cbusy}), 3'b101);
    chk("err_before_rst", int'(cerr), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("after_rst", int'({ca, cb, cbusy, cdone, cpass, cbad, cerr, cfail}), 0);
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cdone) done_cnt++;
    end
    chk("no_done_after_abort", done_cnt, 0);
    run_sweep(3, 3, 0, 0);

    // Held start and toggling func_sel on the short-settle unit
    u = 1;
    run_sweep(3, 3, 1, 1);
    run_sweep(4, 2, 1, 1);

    for (int n = 0; n < 20; n++) begin
      u = int'($urandom_range(0, 1));
      run_sweep(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
